// File: rtl/alu_iterative_exec.sv
// Execution stage: 1-cycle ADD/OR/LUI, bit-serial SLL/SRL with start/busy/done.
// Optional SUB on code 0001 when ALU_SUB_EN is defined.
module alu_iterative_exec #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic [3:0]            ALU_Operation_i,
  input  logic [DATA_WIDTH-1:0] A_i,
  input  logic [DATA_WIDTH-1:0] B_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] ALU_Result_o,
  output logic                  Zero_o,
  output logic                  illegal_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [3:0] OP_ADD = 4'b0000;
`ifdef ALU_SUB_EN
  localparam logic [3:0] OP_SUB = 4'b0001;
`endif
  localparam logic [3:0] OP_OR  = 4'b0010;
  localparam logic [3:0] OP_LUI = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;

  state_t state_q, state_d;

  logic [DATA_WIDTH-1:0]  work_q;
  logic [SHAMT_WIDTH-1:0] cnt_q;
  logic                   dir_q;
  logic [DATA_WIDTH-1:0]  res_q;
  logic                   zero_q;
  logic                   ill_q;

  logic [SHAMT_WIDTH-1:0] shamt;
  logic                   is_shift;
  logic                   accept;
  logic                   long_shift;
  logic                   last_step;
  logic [DATA_WIDTH-1:0]  fast_res;
  logic                   fast_ill;
  logic [DATA_WIDTH-1:0]  work_nxt;

  assign shamt      = B_i[SHAMT_WIDTH-1:0];
  assign is_shift   = (ALU_Operation_i == OP_SLL) ||
                      (ALU_Operation_i == OP_SRL);
  assign accept     = start_i && (state_q != SHIFT);
  assign long_shift = is_shift && (shamt != '0);
  assign last_step  = (cnt_q == SHAMT_WIDTH'(1));
  assign work_nxt   = dir_q ? (work_q >> 1) : (work_q << 1);

  // Single-cycle results; a zero-distance shift passes A through.
  always_comb begin
    fast_res = '0;
    fast_ill = 1'b0;
    unique case (1'b1)
      (ALU_Operation_i == OP_ADD): fast_res = A_i + B_i;
`ifdef ALU_SUB_EN
      (ALU_Operation_i == OP_SUB): fast_res = A_i - B_i;
`endif
      (ALU_Operation_i == OP_OR):  fast_res = A_i | B_i;
      (ALU_Operation_i == OP_LUI): fast_res = B_i;
      is_shift:                    fast_res = A_i;
      default:                     fast_ill = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (accept)
          state_d = long_shift ? SHIFT : DONE;
        else
          state_d = IDLE;
      end
      SHIFT: begin
        if (last_step)
          state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b1;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        if (long_shift) begin
          work_q <= A_i;
          cnt_q  <= shamt;
          dir_q  <= (ALU_Operation_i == OP_SRL);
        end else begin
          res_q  <= fast_res;
          zero_q <= (fast_res == '0);
          ill_q  <= fast_ill;
        end
      end else if (state_q == SHIFT) begin
        work_q <= work_nxt;
        cnt_q  <= cnt_q - SHAMT_WIDTH'(1);
        // Visible result only changes on the final step.
        if (last_step) begin
          res_q  <= work_nxt;
          zero_q <= (work_nxt == '0);
          ill_q  <= 1'b0;
        end
      end
    end
  end

  assign busy_o       = (state_q == SHIFT);
  assign done_o       = (state_q == DONE);
  assign ALU_Result_o = res_q;
  assign Zero_o       = zero_q;
  assign illegal_o    = ill_q;

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Directed bench for alu_iterative_exec.
// Honours ALU_SUB_EN for the SUB expectations.
module tb_alu_iterative_exec;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_i;
  logic [3:0]  ALU_Operation_i;
  logic [31:0] A_i;
  logic [31:0] B_i;
  logic        busy_o;
  logic        done_o;
  logic [31:0] ALU_Result_o;
  logic        Zero_o;
  logic        illegal_o;

  int errors = 0;
  int checks = 0;

  alu_iterative_exec #(
    .DATA_WIDTH (32),
    .SHAMT_WIDTH(5)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start_i),
    .ALU_Operation_i(ALU_Operation_i),
    .A_i            (A_i),
    .B_i            (B_i),
    .busy_o         (busy_o),
    .done_o         (done_o),
    .ALU_Result_o   (ALU_Result_o),
    .Zero_o         (Zero_o),
    .illegal_o      (illegal_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge where done_o is seen.
  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    start_i = 1'b1;
    ALU_Operation_i = op;
    A_i = a;
    B_i = b;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    start_i = 1'b0;
    while (!done_o && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic exp_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input int exp_lat,
                        input logic ill);
    int lat;
    run_op(op, a, b, lat);
    chk({tag, "_done"}, 32'(done_o), 32'd1);
    chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_res"}, ALU_Result_o, res);
    chk({tag, "_zero"}, 32'(Zero_o), 32'(res == 32'd0));
    chk({tag, "_ill"}, 32'(illegal_o), 32'(ill));
    chk({tag, "_busy"}, 32'(busy_o), 32'd0);
  endtask

  initial begin
    int lat;
    reset = 1'b0;
    start_i = 1'b0;
    ALU_Operation_i = 4'b0000;
    A_i = '0;
    B_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_res", ALU_Result_o, 32'd0);
    chk("rst_zero", 32'(Zero_o), 32'd1);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_ill", 32'(illegal_o), 32'd0);
    reset = 1'b1;

    exp_op("add_wrap", 4'b0000, 32'hFFFF_FFFF, 32'd1, 32'd0, 1, 1'b0);
    exp_op("lui", 4'b0100, 32'hDEAD_0000, 32'h1234_5000,
           32'h1234_5000, 1, 1'b0);

    // SLL by 4 with an ignored start while busy.
    start_i = 1'b1;
    ALU_Operation_i = 4'b0101;
    A_i = 32'd1;
    B_i = 32'h0000_0024;
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    chk("sll_busy", 32'(busy_o), 32'd1);
    chk("sll_hold", ALU_Result_o, 32'h1234_5000);
    ALU_Operation_i = 4'b0000;
    A_i = 32'd5;
    B_i = 32'd5;
    @(posedge clk);
    lat++;
    @(negedge clk);
    start_i = 1'b0;
    chk("sll_hold2", ALU_Result_o, 32'h1234_5000);
    while (!done_o && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    chk("sll_lat", 32'(lat), 32'd5);
    chk("sll_res", ALU_Result_o, 32'h0000_0010);
    chk("sll_zero", 32'(Zero_o), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("sll_pulse", 32'(done_o), 32'd0);
    chk("sll_idle", 32'(busy_o), 32'd0);

    exp_op("srl31", 4'b0110, 32'h8000_0000, 32'd31, 32'd1, 32, 1'b0);
    exp_op("srl0", 4'b0110, 32'h0000_1234, 32'd0,
           32'h0000_1234, 1, 1'b0);
    exp_op("sll_up", 4'b0101, 32'h0000_00A5, 32'hFFFF_FFE0,
           32'h0000_00A5, 1, 1'b0);
    exp_op("sll1", 4'b0101, 32'h8000_0001, 32'd1,
           32'h0000_0002, 2, 1'b0);
`ifdef ALU_SUB_EN
    exp_op("sub", 4'b0001, 32'd5, 32'd7, 32'hFFFF_FFFE, 1, 1'b0);
`else
    exp_op("sub", 4'b0001, 32'd5, 32'd7, 32'd0, 1, 1'b1);
`endif
    exp_op("op_f", 4'b1111, 32'd3, 32'd4, 32'd0, 1, 1'b1);
    exp_op("add", 4'b0000, 32'd100, 32'd23, 32'd123, 1, 1'b0);

    // Reset during cycle 2 of an 8-step SLL.
    start_i = 1'b1;
    ALU_Operation_i = 4'b0101;
    A_i = 32'd1;
    B_i = 32'd8;
    @(posedge clk);
    @(negedge clk);
    start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("mid_done", 32'(done_o), 32'd0);
    chk("mid_busy", 32'(busy_o), 32'd0);
    chk("mid_res", ALU_Result_o, 32'd0);
    chk("mid_zero", 32'(Zero_o), 32'd1);
    chk("mid_ill", 32'(illegal_o), 32'd0);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("post_done", 32'(done_o), 32'd0);

    exp_op("or", 4'b0010, 32'h0000_00F0, 32'h0000_000F,
           32'h0000_00FF, 1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
